led_pattern_sequencer: RTL and testbench

Pattern controller for the 8-LED bank on the CPLD board. It replaces eight free-running per-LED blinkers with one shared prescaler and one pattern register, so all LEDs step in lockstep. After reset it runs a lamp test with all LEDs on, then plays one of four selectable patterns. Patterns can be paused and switched at run time.

---
 rtl/led_pattern_sequencer.sv | 176 +++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Eight-LED pattern sequencer: one shared prescaler steps a single pattern register,
// with a lamp test after reset and four run-time selectable, pausable patterns.
module led_pattern_sequencer #(
   parameter int unsigned TICK_DIV   = 5_000_000,
   parameter int unsigned LAMP_STEPS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode,
   input  logic       mode_load,
   input  logic       pause,
   output logic [7:0] LED,
   output logic       step,
   output logic       running
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned LW = $clog2(LAMP_STEPS + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [LW-1:0] LAMP_LAST = LW'(LAMP_STEPS - 1);

   typedef enum logic [1:0] {
      ST_TEST = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  mode_q, mode_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [LW-1:0] lamp_q, lamp_d;
   logic        dir_up_q, dir_up_d;
   logic [7:0]  led_q, led_d;
   logic        step_q, step_d;
   logic        running_q, running_d;
   logic        tick_s;
   logic [PW-1:0] presc_inc_s;
   logic [8:0]  adv_s;

   function automatic logic [7:0] init_pattern(input logic [1:0] m);
      logic [7:0] p;
      case (m)
         2'd1:    p = 8'h01;
         2'd2:    p = 8'h01;
         default: p = 8'h00;
      endcase
      return p;
   endfunction

   // Returns {direction_up, next_led} for one pattern step.
   function automatic logic [8:0] next_pattern(input logic [1:0] m, input logic [7:0] l,
                                               input logic up);
      logic [7:0] n;
      logic       d;
      d = up;
      case (m)
         2'd0: n = ~l;
         2'd1: n = {l[6:0], l[7]};
         2'd2: begin
            if (up) begin
               n = {l[6:0], 1'b0};
               d = (n != 8'h80);
            end else begin
               n = {1'b0, l[7:1]};
               d = (n == 8'h01);
            end
         end
         default: n = l + 8'd1;
      endcase
      return {d, n};
   endfunction

   // Next-state, prescaler and pattern logic.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      presc_d     = presc_q;
      lamp_d      = lamp_q;
      dir_up_d    = dir_up_q;
      led_d       = led_q;
      step_d      = 1'b0;
      tick_s      = (presc_q == PRESC_MAX) && (state_q != ST_HOLD);
      presc_inc_s = (presc_q == PRESC_MAX) ? {PW{1'b0}} : presc_q + PW'(1);
      adv_s       = next_pattern(mode_q, led_q, dir_up_q);

      case (state_q)
         ST_TEST: begin
            led_d   = 8'hFF;
            presc_d = presc_inc_s;
            if (mode_load) begin
               mode_d = mode;
            end else begin
               mode_d = mode_q;
            end
            if (tick_s) begin
               step_d = 1'b1;
               lamp_d = lamp_q + LW'(1);
               if (lamp_q == LAMP_LAST) begin
                  state_d  = ST_RUN;
                  led_d    = init_pattern(mode_d);
                  dir_up_d = 1'b1;
               end else begin
                  state_d = ST_TEST;
               end
            end else begin
               lamp_d = lamp_q;
            end
         end
         ST_RUN: begin
            if (mode_load) begin
               // A reload restarts the pattern and its timing; it is not a step.
               mode_d   = mode;
               led_d    = init_pattern(mode);
               dir_up_d = 1'b1;
               presc_d  = {PW{1'b0}};
               state_d  = pause ? ST_HOLD : ST_RUN;
            end else if (pause) begin
               state_d = ST_HOLD;
            end else begin
               presc_d = presc_inc_s;
               if (tick_s) begin
                  step_d   = 1'b1;
                  led_d    = adv_s[7:0];
                  dir_up_d = adv_s[8];
               end else begin
                  step_d = 1'b0;
               end
            end
         end
         ST_HOLD: begin
            if (mode_load) begin
               mode_d   = mode;
               led_d    = init_pattern(mode);
               dir_up_d = 1'b1;
               presc_d  = {PW{1'b0}};
            end else begin
               presc_d = presc_q;
            end
            state_d = pause ? ST_HOLD : ST_RUN;
         end
         default: begin
            state_d = ST_TEST;
         end
      endcase

      running_d = (state_d == ST_RUN);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_TEST;
         mode_q    <= 2'd0;
         presc_q   <= {PW{1'b0}};
         lamp_q    <= {LW{1'b0}};
         dir_up_q  <= 1'b1;
         led_q     <= 8'hFF;
         step_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         presc_q   <= presc_d;
         lamp_q    <= lamp_d;
         dir_up_q  <= dir_up_d;
         led_q     <= led_d;
         step_q    <= step_d;
         running_q <= running_d;
      end
   end

   assign LED     = led_q;
   assign step    = step_q;
   assign running = running_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with TICK_DIV=4, LAMP_STEPS=2:
// a per-cycle vector table followed by multi-cycle pattern sequences.
module tb_led_pattern_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic       mode_load;
   logic       pause;
   logic [7:0] LED;
   logic       step;
   logic       running;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       rst;
      logic [1:0] mode;
      logic       ld;
      logic       pause;
      logic [7:0] led;
      logic       step;
      logic       run;
   } vec_t;

   vec_t vecs[$];

   led_pattern_sequencer #(.TICK_DIV(4), .LAMP_STEPS(2)) dut (
      .clk(clk), .rst(rst), .mode(mode), .mode_load(mode_load), .pause(pause),
      .LED(LED), .step(step), .running(running)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic void add(input logic r, input logic [1:0] m, input logic l, input logic p,
                               input logic [7:0] e_led, input logic e_step, input logic e_run);
      vec_t v;
      v.rst = r; v.mode = m; v.ld = l; v.pause = p;
      v.led = e_led; v.step = e_step; v.run = e_run;
      vecs.push_back(v);
   endfunction

   task automatic tick_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; mode_load = 1'b0; pause = 1'b0; mode = 2'd0;
      tick_cycle();
      rst = 1'b0;
   endtask

   task automatic wait_step(output int n);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick_cycle();
         n++;
         if (step === 1'b1) return;
      end
      n = 99;
   endtask

   task automatic load_mode_in_test(input logic [1:0] m);
      do_reset();
      tick_cycle();
      mode = m; mode_load = 1'b1;
      tick_cycle();
      mode_load = 1'b0;
      for (int k = 0; k < 6; k++) tick_cycle();
   endtask

   initial begin
      int n;
      logic [7:0] e;
      logic [7:0] pp[16];
      rst = 1'b1; mode = 2'd0; mode_load = 1'b0; pause = 1'b0;

      // Reset and lamp test into BLINK, cycles 0..13.
      add(1'b1, 2'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
      for (int c = 1; c < 8; c++) add(1'b0, 2'd0, 1'b0, 1'b0, 8'hFF, (c == 4), 1'b0);
      add(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      for (int c = 9; c < 12; c++) add(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      add(1'b0, 2'd0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1);
      add(1'b0, 2'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
      // Pause for 10 cycles with prescaler at 1, then resume keeping the phase.
      for (int c = 0; c < 10; c++) add(1'b0, 2'd0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) add(1'b0, 2'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
      add(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      // Reload to CHASE in RUN: initial pattern now, first step four cycles later.
      add(1'b0, 2'd1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) add(1'b0, 2'd1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1);
      add(1'b0, 2'd1, 1'b0, 1'b0, 8'h02, 1'b1, 1'b1);
      // Reload to COUNT together with pause: load applies and state goes to HOLD.
      add(1'b0, 2'd3, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
      add(1'b0, 2'd3, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) add(1'b0, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      add(1'b0, 2'd3, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; mode = vecs[i].mode; mode_load = vecs[i].ld; pause = vecs[i].pause;
         tick_cycle();
         check($sformatf("vec%0d {led,step,run}", i), {23'd0, LED, step, running},
               {23'd0, vecs[i].led, vecs[i].step, vecs[i].run});
      end

      // CHASE loaded during lamp test, then a full rotation back to 0x01.
      load_mode_in_test(2'd1);
      check("chase_entry", {22'd0, LED, step, running}, {22'd0, 8'h01, 1'b1, 1'b1});
      for (int i = 1; i <= 8; i++) begin
         wait_step(n);
         e = 8'(32'd1 << (i % 8));
         check($sformatf("chase_period%0d", i), n, 32'd4);
         check($sformatf("chase_led%0d", i), {24'd0, LED}, {24'd0, e});
      end

      // PINGPONG bounce: each end value is shown for a single step.
      pp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
             8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      load_mode_in_test(2'd2);
      check("pp_entry", {24'd0, LED}, {24'd0, pp[0]});
      for (int i = 1; i < 16; i++) begin
         wait_step(n);
         check($sformatf("pp_led%0d", i), {24'd0, LED}, {24'd0, pp[i]});
      end

      // COUNT through its wrap, then reload to BLINK on a tick edge.
      load_mode_in_test(2'd3);
      check("count_entry", {24'd0, LED}, 32'h00);
      for (int i = 1; i <= 256; i++) begin
         wait_step(n);
         e = 8'(i);
         check($sformatf("count_period%0d", i), n, 32'd4);
         check($sformatf("count_led%0d", i), {24'd0, LED}, {24'd0, e});
      end
      for (int k = 0; k < 3; k++) tick_cycle();
      mode = 2'd0; mode_load = 1'b1;
      tick_cycle();
      mode_load = 1'b0;
      check("reload_on_tick", {22'd0, LED, step, running}, {22'd0, 8'h00, 1'b0, 1'b1});
      wait_step(n);
      check("reload_next_period", n, 32'd4);
      check("reload_next_led", {24'd0, LED}, 32'hFF);

      // Reset while held in COUNT at 0x37 restarts the full lamp test.
      load_mode_in_test(2'd3);
      for (int i = 0; i < 55; i++) wait_step(n);
      pause = 1'b1;
      tick_cycle();
      tick_cycle();
      check("hold_state", {22'd0, LED, step, running}, {22'd0, 8'h37, 1'b0, 1'b0});
      rst = 1'b1;
      tick_cycle();
      check("reset_in_hold", {22'd0, LED, step, running}, {22'd0, 8'hFF, 1'b0, 1'b0});
      rst = 1'b0; pause = 1'b0;
      for (int k = 0; k < 7; k++) tick_cycle();
      check("retest_cycle7", {22'd0, LED, step, running}, {22'd0, 8'hFF, 1'b0, 1'b0});
      tick_cycle();
      check("retest_cycle8", {22'd0, LED, step, running}, {22'd0, 8'h00, 1'b1, 1'b1});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
